alu_decimal_seq: RTL and testbench
==================================

Name: alu_decimal_seq

Overview:
Parametrised, handshaked successor to the combinational CPU ALU. It executes the same op set (ctrl_alu_op_t) at configurable WIDTH, with registered results and valid/ready flow control. When DEC_EN=1 it also supports digit-serial BCD add/subtract, one nibble per cycle, for 6502 decimal mode. It sits between the CPU sequencer (or a future wide-arith coprocessor) and the flag/register writeback.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of 4, minimum 4
DEC_EN, 0, 1 enables the BCD path; 0 for the 2A03, which has decimal mode removed
NIB (localparam), WIDTH/4, digit count

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any in-flight or held op
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid & req_ready
req_op  in  ctrl_alu_op_t  HOLD/ADD/AND/OR/XOR/SHIFT_LEFT/SHIFT_RIGHT
req_src1  in  WIDTH  operand 1
req_src2  in  WIDTH  operand 2
req_src2_inv  in  1  invert src2 (binary) / subtract (decimal)
req_c_in  in  1  carry in (borrow-not in subtract)
req_decimal  in  1  BCD mode request; ignored unless DEC_EN=1 and req_op=ADD
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_out  out  WIDTH  result
resp_c, resp_v, resp_z, resp_n  out  1 each  flags
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except req_ready=1.
- States: IDLE, DIGIT, DONE.
- req_ready = !flush & (IDLE | (DONE & resp_ready)). This allows back-to-back ops with no bubble.
- Binary accept: at the accepting edge the result and flags are registered and the block moves to DONE. resp_valid is high the next cycle, so latency is 1.
- Binary arithmetic matches the existing ALU, widened:
  - ADD: src2' = inv ? ~src2 : src2; sum = src1 + src2' + c_in over WIDTH+1 bits.
  - c = sum[WIDTH]; v = c ^ carry into bit WIDTH-1.
  - SHIFT_LEFT: {src1[W-2:0], c_in}, c = src1[W-1].
  - SHIFT_RIGHT: {c_in, src1[W-1:1]}, c = src1[0].
  - AND/OR/XOR: c = 0, v = 0.
  - HOLD: out 0, all flags except z are 0; z = 1.
  - z = (out == 0); n = out[W-1].
- Decimal accept (DEC_EN & op=ADD & req_decimal): operands are latched, the digit index is cleared, and the block enters DIGIT.
  - Each DIGIT cycle processes nibble i, LSB first. Digit carry starts at req_c_in.
  - Add: d = a + b + c. If d > 9: d = (d + 6) mod 16, c = 1. Else c = 0.
  - Subtract (src2_inv=1): src2 is used raw, not inverted. d = a - b - !c. If d < 0: d = (d - 6) mod 16, c = 0. Else c = 1.
  - Invalid BCD digits are processed with the same formulas, with no error indication.
  - After nibble NIB-1 the block goes to DONE. Total latency is NIB+1 cycles from accept to resp_valid.
  - Decimal flags: c = final digit carry; z and n taken from the corrected result; v = the binary-mode v for the same operands with src2 inverted when subtracting.
- DONE: outputs are held stable while resp_valid & !resp_ready. On resp_ready the block returns to IDLE, or accepts a new request in the same cycle.
- flush=1 at any state: next state IDLE, resp_valid=0, the in-flight result is discarded, and no request is accepted that cycle. flush has priority over all other inputs.
- DEC_EN=0: the DIGIT state is unreachable and req_decimal is ignored.
- An asynchronous reset mid-DIGIT or mid-DONE is identical to a power-on reset.

Decomposition:
- Shared CPU package: ctrl_alu_op_t (existing), plus new alu_seq_state_t enum {ALUS_IDLE, ALUS_DIGIT, ALUS_DONE}.
- NIB stays a local parameter.
- One combinational sub-module, bcd_digit_unit: 4-bit a, b, carry in, sub → 4-bit digit, carry out.

Test Plan:
1. W=8, binary ADD 0x50+0x50, c_in=0 → after 1 cycle: out=0xA0, c=0, v=1, n=1, z=0.
2. W=8, DEC_EN=1, decimal ADD 0x58+0x46, c_in=1 → after 3 cycles: out=0x05, c=1, z=0. Then decimal SUB 0x46-0x12, c_in=1 → out=0x34, c=1.
3. W=16, DEC_EN=1, decimal ADD 0x9999+0x0001, c_in=0 → busy for 5 cycles; out=0x0000, c=1, z=1.
4. SHIFT_RIGHT 0x01, c_in=1 → out=0x80, c=1, n=1. Hold resp_ready=0 for 4 cycles → outputs stable and req_ready=0. Then release with a new req_valid the same cycle → accepted with no bubble.
5. Decimal op, assert flush during the 2nd DIGIT cycle with req_valid=1 → next cycle IDLE, resp_valid never rises, the request is not accepted that cycle.
6. DEC_EN=0, req_decimal=1, ADD 0x09+0x01 → binary result out=0x0A after 1 cycle. Separately, reset_n pulse mid-DONE → all outputs 0, req_ready=1 immediately.

Source files
------------

// File: rtl/alu_decimal_seq_pkg.sv
// Shared CPU ALU types: operation encoding, sequencer states and a small
// overflow helper used by the handshaked ALU.
package alu_decimal_seq_pkg;

    typedef enum logic [2:0] {
        ALU_OP_HOLD        = 3'd0,
        ALU_OP_ADD         = 3'd1,
        ALU_OP_AND         = 3'd2,
        ALU_OP_OR          = 3'd3,
        ALU_OP_XOR         = 3'd4,
        ALU_OP_SHIFT_LEFT  = 3'd5,
        ALU_OP_SHIFT_RIGHT = 3'd6
    } ctrl_alu_op_t;

    typedef enum logic [1:0] {
        ALUS_IDLE  = 2'd0,
        ALUS_DIGIT = 2'd1,
        ALUS_DONE  = 2'd2
    } alu_seq_state_t;

    localparam int DIGIT_W = 4;

    // Two's-complement overflow from the sign bits of both addends and the sum.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_decimal_seq_bcd_digit.sv
// One BCD digit of add/subtract with decimal correction; invalid digits
// go through the same arithmetic without any error indication.
module bcd_digit_unit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    input  logic       sub_i,
    output logic [3:0] d_o,
    output logic       c_o
);
    logic [4:0] sum_s;
    logic [4:0] diff_s;

    // Binary digit sum/difference, then decimal correction of the digit.
    always_comb begin
        sum_s  = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
        diff_s = {1'b0, a_i} - {1'b0, b_i} - {4'b0000, ~c_i};
        d_o    = 4'd0;
        c_o    = 1'b0;
        if (sub_i) begin
            // Carry doubles as borrow-not; a negative 5-bit difference means borrow.
            if (diff_s[4]) begin
                d_o = diff_s[3:0] - 4'd6;
                c_o = 1'b0;
            end else begin
                d_o = diff_s[3:0];
                c_o = 1'b1;
            end
        end else begin
            if (sum_s > 5'd9) begin
                d_o = sum_s[3:0] + 4'd6;
                c_o = 1'b1;
            end else begin
                d_o = sum_s[3:0];
                c_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_decimal_seq.sv
// Handshaked ALU: binary ops complete in one cycle; with DEC_EN, BCD
// add/subtract runs one nibble per cycle, LSB first.
module alu_decimal_seq
    import alu_decimal_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit DEC_EN = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  ctrl_alu_op_t     req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             req_src2_inv,
    input  logic             req_c_in,
    input  logic             req_decimal,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_c,
    output logic             resp_v,
    output logic             resp_z,
    output logic             resp_n,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    alu_seq_state_t state_q, state_d;

    logic             accept_s;
    logic             dec_go_s;
    logic [WIDTH-1:0] src2_eff_s;
    logic [WIDTH:0]   add_s;
    logic             add_v_s;
    logic [WIDTH-1:0] bin_out_s;
    logic             bin_c_s;
    logic             bin_v_s;
    logic             bin_z_s;
    logic             bin_n_s;

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry_q, sub_q;
    logic [CW-1:0]    idx_q;
    logic             c_q, v_q, z_q, n_q;

    logic [3:0]       dig_d_s;
    logic             dig_c_s;
    logic [WIDTH+3:0] res_shift_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;

    assign accept_s = req_valid & req_ready;
    assign dec_go_s = DEC_EN && (req_op == ALU_OP_ADD) && req_decimal;
    assign last_s   = (idx_q == CW'(NIB - 1));

    bcd_digit_unit u_digit (
        .a_i   (a_q[3:0]),
        .b_i   (b_q[3:0]),
        .c_i   (carry_q),
        .sub_i (sub_q),
        .d_o   (dig_d_s),
        .c_o   (dig_c_s)
    );

    // New digit enters at the top; after NIB shifts the result is aligned.
    always_comb begin
        res_shift_s = {dig_d_s, res_q} >> 3'd4;
        res_next_s  = res_shift_s[WIDTH-1:0];
    end

    // Single-cycle binary result and flags for the presented request.
    always_comb begin
        src2_eff_s = req_src2_inv ? ~req_src2 : req_src2;
        add_s      = {1'b0, req_src1} + {1'b0, src2_eff_s} + {{WIDTH{1'b0}}, req_c_in};
        add_v_s    = add_overflow(req_src1[WIDTH-1], src2_eff_s[WIDTH-1], add_s[WIDTH-1]);
        bin_out_s  = {WIDTH{1'b0}};
        bin_c_s    = 1'b0;
        bin_v_s    = 1'b0;
        case (req_op)
            ALU_OP_ADD: begin
                bin_out_s = add_s[WIDTH-1:0];
                bin_c_s   = add_s[WIDTH];
                bin_v_s   = add_v_s;
            end
            ALU_OP_AND:         bin_out_s = req_src1 & req_src2;
            ALU_OP_OR:          bin_out_s = req_src1 | req_src2;
            ALU_OP_XOR:         bin_out_s = req_src1 ^ req_src2;
            ALU_OP_SHIFT_LEFT: begin
                bin_out_s = {req_src1[WIDTH-2:0], req_c_in};
                bin_c_s   = req_src1[WIDTH-1];
            end
            ALU_OP_SHIFT_RIGHT: begin
                bin_out_s = {req_c_in, req_src1[WIDTH-1:1]};
                bin_c_s   = req_src1[0];
            end
            default: begin
                bin_out_s = {WIDTH{1'b0}};
                bin_c_s   = 1'b0;
                bin_v_s   = 1'b0;
            end
        endcase
        bin_z_s = (bin_out_s == {WIDTH{1'b0}});
        bin_n_s = bin_out_s[WIDTH-1];
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ALUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ALUS_IDLE;
        end else begin
            case (state_q)
                ALUS_IDLE: begin
                    if (accept_s) begin
                        state_d = dec_go_s ? ALUS_DIGIT : ALUS_DONE;
                    end else begin
                        state_d = ALUS_IDLE;
                    end
                end
                ALUS_DIGIT: begin
                    if (last_s) begin
                        state_d = ALUS_DONE;
                    end else begin
                        state_d = ALUS_DIGIT;
                    end
                end
                ALUS_DONE: begin
                    if (accept_s) begin
                        state_d = dec_go_s ? ALUS_DIGIT : ALUS_DONE;
                    end else if (resp_ready) begin
                        state_d = ALUS_IDLE;
                    end else begin
                        state_d = ALUS_DONE;
                    end
                end
                default: state_d = ALUS_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        req_ready  = !flush && ((state_q == ALUS_IDLE) ||
                                ((state_q == ALUS_DONE) && resp_ready));
        resp_valid = (state_q == ALUS_DONE);
        busy       = (state_q != ALUS_IDLE);
    end

    // Operand latches, digit sequencing and registered result/flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            idx_q   <= {CW{1'b0}};
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else if (flush) begin
            res_q   <= {WIDTH{1'b0}};
            idx_q   <= {CW{1'b0}};
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else if (accept_s) begin
            if (dec_go_s) begin
                a_q     <= req_src1;
                b_q     <= req_src2;
                carry_q <= req_c_in;
                sub_q   <= req_src2_inv;
                idx_q   <= {CW{1'b0}};
                res_q   <= {WIDTH{1'b0}};
                c_q     <= 1'b0;
                v_q     <= add_v_s;
                z_q     <= 1'b0;
                n_q     <= 1'b0;
            end else begin
                res_q   <= bin_out_s;
                c_q     <= bin_c_s;
                v_q     <= bin_v_s;
                z_q     <= bin_z_s;
                n_q     <= bin_n_s;
            end
        end else if (state_q == ALUS_DIGIT) begin
            a_q     <= a_q >> 3'd4;
            b_q     <= b_q >> 3'd4;
            res_q   <= res_next_s;
            carry_q <= dig_c_s;
            idx_q   <= idx_q + CW'(1);
            if (last_s) begin
                c_q <= dig_c_s;
                z_q <= (res_next_s == {WIDTH{1'b0}});
                n_q <= res_next_s[WIDTH-1];
            end
        end
    end

    assign resp_out = res_q;
    assign resp_c   = c_q;
    assign resp_v   = v_q;
    assign resp_z   = z_q;
    assign resp_n   = n_q;

endmodule

// File: tb/tb_alu_decimal_seq.sv
// Randomized self-checking bench for alu_decimal_seq: three instances
// (8-bit decimal, 16-bit decimal, 8-bit binary-only) behind one driver.
module tb_alu_decimal_seq;
    import alu_decimal_seq_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n, flush, req_valid, resp_ready;
    logic         req_src2_inv, req_c_in, req_decimal;
    ctrl_alu_op_t req_op;
    logic [15:0]  req_src1, req_src2;
    int           sel;

    logic [2:0]   vld_s, rdy_s, rv_s, busy_s, c_s, v_s, z_s, n_s;
    logic [7:0]   out_a, out_c;
    logic [15:0]  out_b;

    logic         m_rdy, m_rv, m_busy, m_c, m_v, m_z, m_n;
    logic [15:0]  m_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    assign vld_s[0] = req_valid && (sel == 0);
    assign vld_s[1] = req_valid && (sel == 1);
    assign vld_s[2] = req_valid && (sel == 2);

    alu_decimal_seq #(.WIDTH(8), .DEC_EN(1'b1)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(vld_s[0]), .req_ready(rdy_s[0]), .req_op(req_op),
        .req_src1(req_src1[7:0]), .req_src2(req_src2[7:0]),
        .req_src2_inv(req_src2_inv), .req_c_in(req_c_in), .req_decimal(req_decimal),
        .resp_valid(rv_s[0]), .resp_ready(resp_ready), .resp_out(out_a),
        .resp_c(c_s[0]), .resp_v(v_s[0]), .resp_z(z_s[0]), .resp_n(n_s[0]), .busy(busy_s[0]));

    alu_decimal_seq #(.WIDTH(16), .DEC_EN(1'b1)) u_dut16 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(vld_s[1]), .req_ready(rdy_s[1]), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .req_src2_inv(req_src2_inv), .req_c_in(req_c_in), .req_decimal(req_decimal),
        .resp_valid(rv_s[1]), .resp_ready(resp_ready), .resp_out(out_b),
        .resp_c(c_s[1]), .resp_v(v_s[1]), .resp_z(z_s[1]), .resp_n(n_s[1]), .busy(busy_s[1]));

    alu_decimal_seq #(.WIDTH(8), .DEC_EN(1'b0)) u_dut8b (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(vld_s[2]), .req_ready(rdy_s[2]), .req_op(req_op),
        .req_src1(req_src1[7:0]), .req_src2(req_src2[7:0]),
        .req_src2_inv(req_src2_inv), .req_c_in(req_c_in), .req_decimal(req_decimal),
        .resp_valid(rv_s[2]), .resp_ready(resp_ready), .resp_out(out_c),
        .resp_c(c_s[2]), .resp_v(v_s[2]), .resp_z(z_s[2]), .resp_n(n_s[2]), .busy(busy_s[2]));

    always_comb begin
        m_rdy  = rdy_s[sel];
        m_rv   = rv_s[sel];
        m_busy = busy_s[sel];
        m_c    = c_s[sel];
        m_v    = v_s[sel];
        m_z    = z_s[sel];
        m_n    = n_s[sel];
        case (sel)
            0:       m_out = {8'h00, out_a};
            1:       m_out = out_b;
            default: m_out = {8'h00, out_c};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (sel %0d)", tag, got, exp, sel);
        else n_pass++;
    endtask

    function automatic int width_of(input int s);
        return (s == 1) ? 16 : 8;
    endfunction

    // Reference: integer arithmetic straight from the operation definitions.
    function automatic void model(input int w, input bit den, input ctrl_alu_op_t op,
                                  input int a, input int b, input bit inv, input bit cin,
                                  input bit dec, output int o, output int c, output int v,
                                  output int z, output int n, output int lat);
        int mask, half, bb, us, sa, sb, ss, da, db, d, cc;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        bb   = inv ? ((~b) & mask) : b;
        us   = a + bb + int'(cin);
        sa   = (a  >= half) ? a  - (1 << w) : a;
        sb   = (bb >= half) ? bb - (1 << w) : bb;
        ss   = sa + sb + int'(cin);
        o = 0; c = 0; v = 0; lat = 1;
        case (op)
            ALU_OP_ADD: begin
                v = ((ss > half - 1) || (ss < -half)) ? 1 : 0;
                if (den && dec) begin
                    cc = int'(cin);
                    for (int i = 0; i < w / 4; i++) begin
                        da = (a >> (4 * i)) & 15;
                        db = (b >> (4 * i)) & 15;
                        if (!inv) begin
                            d = da + db + cc;
                            if (d > 9) begin d = (d + 6) % 16; cc = 1; end
                            else cc = 0;
                        end else begin
                            d = da - db - (1 - cc);
                            if (d < 0) begin d = (d - 6) & 15; cc = 0; end
                            else cc = 1;
                        end
                        o = o | (d << (4 * i));
                    end
                    c   = cc;
                    lat = w / 4 + 1;
                end else begin
                    o = us & mask;
                    c = (us >> w) & 1;
                end
            end
            ALU_OP_AND:         o = a & b;
            ALU_OP_OR:          o = a | b;
            ALU_OP_XOR:         o = a ^ b;
            ALU_OP_SHIFT_LEFT:  begin o = ((a << 1) | int'(cin)) & mask; c = (a >> (w - 1)) & 1; end
            ALU_OP_SHIFT_RIGHT: begin o = (int'(cin) << (w - 1)) | (a >> 1); c = a & 1; end
            default:            o = 0;
        endcase
        z = (o == 0) ? 1 : 0;
        n = (o >> (w - 1)) & 1;
    endfunction

    task automatic drive_req(input ctrl_alu_op_t op, input int a, input int b,
                             input bit inv, input bit cin, input bit dec);
        req_op = op; req_src1 = a[15:0]; req_src2 = b[15:0];
        req_src2_inv = inv; req_c_in = cin; req_decimal = dec; req_valid = 1'b1;
    endtask

    task automatic check_resp(input int eo, input int ec, input int ev, input int ez, input int en);
        chk("out", 32'(m_out), eo);
        chk("c", 32'(m_c), ec);
        chk("v", 32'(m_v), ev);
        chk("z", 32'(m_z), ez);
        chk("n", 32'(m_n), en);
    endtask

    // One transaction from IDLE: accept, latency, result, backpressure, release.
    task automatic run_op(input ctrl_alu_op_t op, input int a_in, input int b_in,
                          input bit inv, input bit cin, input bit dec, input int hold);
        int w, a, b, eo, ec, ev, ez, en, elat, cyc;
        w = width_of(sel);
        a = a_in & ((1 << w) - 1);
        b = b_in & ((1 << w) - 1);
        model(w, sel != 2, op, a, b, inv, cin, dec, eo, ec, ev, ez, en, elat);
        @(negedge clock);
        drive_req(op, a, b, inv, cin, dec);
        resp_ready = 1'b0;
        #1 chk("accept_rdy", 32'(m_rdy), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 1;
        while (!m_rv && cyc < 40) begin
            chk("busy_wait", 32'(m_busy), 32'd1);
            @(negedge clock);
            cyc++;
        end
        chk("latency", 32'(cyc), elat);
        check_resp(eo, ec, ev, ez, en);
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            chk("hold_valid", 32'(m_rv), 32'd1);
            chk("hold_out", 32'(m_out), eo);
            chk("hold_rdy", 32'(m_rdy), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        #1 chk("release_idle", 32'(m_rv), 32'd0);
    endtask

    initial begin
        int eo, ec, ev, ez, en, elat, a, b, cyc;
        ctrl_alu_op_t op;
        bit dec, inv;

        sel = 0; reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = ALU_OP_HOLD; req_src1 = 16'h0; req_src2 = 16'h0;
        req_src2_inv = 1'b0; req_c_in = 1'b0; req_decimal = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_rdy", 32'(m_rdy), 32'd1);
            chk("rst_valid", 32'(m_rv), 32'd0);
            chk("rst_busy", 32'(m_busy), 32'd0);
            check_resp(0, 0, 0, 0, 0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // Directed cases from the operation examples.
        sel = 0;
        run_op(ALU_OP_ADD, 'h50, 'h50, 1'b0, 1'b0, 1'b0, 0);
        run_op(ALU_OP_ADD, 'h58, 'h46, 1'b0, 1'b1, 1'b1, 0);
        run_op(ALU_OP_ADD, 'h46, 'h12, 1'b1, 1'b1, 1'b1, 0);
        run_op(ALU_OP_SHIFT_RIGHT, 'h01, 'h00, 1'b0, 1'b1, 1'b0, 4);
        sel = 1;
        run_op(ALU_OP_ADD, 'h9999, 'h0001, 1'b0, 1'b0, 1'b1, 0);
        sel = 2;
        run_op(ALU_OP_ADD, 'h09, 'h01, 1'b0, 1'b0, 1'b1, 0);

        // Back-to-back: release and new request in the same cycle.
        sel = 0;
        @(negedge clock);
        drive_req(ALU_OP_SHIFT_RIGHT, 'h01, 'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        req_valid = 1'b0;
        chk("b2b_first", 32'(m_out), 32'h80);
        model(8, 1'b1, ALU_OP_XOR, 'h3C, 'hA5, 1'b0, 1'b0, 1'b0, eo, ec, ev, ez, en, elat);
        drive_req(ALU_OP_XOR, 'h3C, 'hA5, 1'b0, 1'b0, 1'b0);
        resp_ready = 1'b1;
        #1 chk("b2b_rdy", 32'(m_rdy), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        chk("b2b_valid", 32'(m_rv), 32'd1);
        check_resp(eo, ec, ev, ez, en);
        @(negedge clock);
        resp_ready = 1'b0;
        #1 chk("b2b_idle", 32'(m_rv), 32'd0);

        // Flush during the second digit cycle with a competing request.
        @(negedge clock);
        drive_req(ALU_OP_ADD, 'h58, 'h46, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        drive_req(ALU_OP_AND, 'hFF, 'h0F, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1 chk("flush_rdy", 32'(m_rdy), 32'd0);
        @(negedge clock);
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_busy", 32'(m_busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("flush_valid", 32'(m_rv), 32'd0);
            @(negedge clock);
        end

        // Asynchronous reset while a result is held.
        sel = 1;
        drive_req(ALU_OP_ADD, 'h1234, 'h4321, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        req_valid = 1'b0;
        chk("pre_rst_valid", 32'(m_rv), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_rdy", 32'(m_rdy), 32'd1);
        chk("arst_valid", 32'(m_rv), 32'd0);
        chk("arst_busy", 32'(m_busy), 32'd0);
        check_resp(0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic over all three configurations.
        for (int i = 0; i < 150; i++) begin
            sel = i % 3;
            op  = ctrl_alu_op_t'(3'($urandom_range(0, 6)));
            dec = ($urandom_range(0, 3) != 0);
            inv = (op == ALU_OP_ADD) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = int'($urandom & 32'hFFFF);
            b = int'($urandom & 32'hFFFF);
            if (op == ALU_OP_ADD && dec && $urandom_range(0, 7) != 0) begin
                a = 0; b = 0;
                for (int d = 0; d < 4; d++) begin
                    a = a | (int'($urandom_range(0, 9)) << (4 * d));
                    b = b | (int'($urandom_range(0, 9)) << (4 * d));
                end
            end
            run_op(op, a, b, inv, 1'($urandom_range(0, 1)), dec, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
